// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-in, parallel-out deserializer with a one-word holding register on a
// valid/ready output interface and a sticky overflow flag for dropped words.
//
// Build option: define PARITY_CHECK_EN to extend each frame with a trailing
// even-parity bit. That bit is checked into PAR_ERR and is not shifted into O.
// With the macro undefined, frames are WIDTH bits long and PAR_ERR is tied low.

module sipo_deserializer #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             I,
   input  logic             I_VALID,
   output logic [WIDTH-1:0] O,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic             OVERFLOW,
   output logic             PAR_ERR
);

`ifdef PARITY_CHECK_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif
   localparam int unsigned      CNT_W    = $clog2(FRAME);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Holding register states
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Bit assembly
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] shifted;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             complete;
   logic [WIDTH-1:0] word;

   // Holding register
   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] o_q, o_d;
   logic             ovf_q, ovf_d;

`ifdef PARITY_CHECK_EN
   logic             word_perr;
   logic             perr_q, perr_d;
`endif

   // Shift register contents after accepting the incoming bit
   always_comb begin
      if (MSB_FIRST) begin
         shifted = {shift_q[WIDTH-2:0], I};
      end else begin
         shifted = {I, shift_q[WIDTH-1:1]};
      end
   end

   // Bit counter, shift register update and word-completion detection
   always_comb begin
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      complete = 1'b0;
`ifdef PARITY_CHECK_EN
      // The final bit of a frame is parity: it is checked, not shifted in,
      // so the completed word is the shift register as it stands.
      word      = shift_q;
      word_perr = (^shift_q) ^ I;
`else
      // The completed word includes the bit arriving on this edge.
      word = shifted;
`endif
      if (I_VALID) begin
         complete = (cnt_q == CNT_LAST);
         cnt_d    = complete ? '0 : cnt_q + CNT_ONE;
`ifdef PARITY_CHECK_EN
         if (!complete) begin
            shift_d = shifted;
         end
`else
         shift_d = shifted;
`endif
      end
   end

   // Holding register: load, drain, simultaneous drain/refill, or drop
   always_comb begin
      state_d = state_q;
      o_d     = o_q;
      ovf_d   = ovf_q;
`ifdef PARITY_CHECK_EN
      perr_d  = perr_q;
`endif
      case (state_q)
         ST_EMPTY: begin
            // O_READY has no effect while nothing is held.
            if (complete) begin
               state_d = ST_FULL;
               o_d     = word;
`ifdef PARITY_CHECK_EN
               perr_d  = word_perr;
`endif
            end
         end
         ST_FULL: begin
            if (complete) begin
               if (O_READY) begin
                  // Consumer takes the held word on the same edge the next
                  // one lands, so there is neither a bubble nor a drop.
                  o_d    = word;
`ifdef PARITY_CHECK_EN
                  perr_d = word_perr;
`endif
               end else begin
                  // Held word is kept; the new one is lost.
                  ovf_d = 1'b1;
               end
            end else if (O_READY) begin
               // O keeps its stale contents once drained.
               state_d = ST_EMPTY;
            end
         end
      endcase
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         shift_q <= '0;
         cnt_q   <= '0;
         state_q <= ST_EMPTY;
         o_q     <= '0;
         ovf_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         o_q     <= o_d;
         ovf_q   <= ovf_d;
`ifdef PARITY_CHECK_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign O        = o_q;
   assign O_VALID  = (state_q == ST_FULL);
   assign OVERFLOW = ovf_q;
`ifdef PARITY_CHECK_EN
   assign PAR_ERR  = perr_q;
`else
   assign PAR_ERR  = 1'b0;
`endif

endmodule
